fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath. It owns the program counter, drives the instruction-memory read request, and presents a held, flushable instruction word to the decode stage. That instruction word is the `instr` input of the control unit. A one-entry buffer keeps an instruction that returns from memory while decode is stalled, so it is not lost.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory has returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word from memory; valid only when ihit=1.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction fetch address; equals current PC.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 00.
- halt  in  1  halt decoded downstream; stops fetch permanently until reset.
- ifid_instr  out  32  latched instruction, drives control unit instr.
- ifid_pc  out  32  PC of ifid_instr.
- ifid_npc  out  32  ifid_pc + 4.
- ifid_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- halted  out  1  the stage is in the HALTED state.

## Operation
- States: FETCH, BUFFERED, HALTED. Reset state is FETCH.
- Event priority each cycle: RST > halt > redirect > stall > ihit.
- FETCH:
  - imemREN=1, imemaddr=pc.
  - ihit & !stall: IF/ID <= {imemload, pc, pc+4}, valid=1; pc <= pc+4.
  - ihit & stall: buf <= {imemload, pc}; IF/ID held; pc held; go to BUFFERED.
  - !ihit & !stall: ifid_valid <= 0 (bubble); other IF/ID fields may hold.
  - !ihit & stall: everything held.
- BUFFERED:
  - imemREN=0.
  - !stall: IF/ID <= {buf_instr, buf_pc, buf_pc+4}, valid=1; pc <= buf_pc+4; go to FETCH.
  - stall: hold.
- redirect (any non-HALTED state):
  - pc <= redirect_pc & ~3.
  - IF/ID flushed: ifid_valid <= 0, ifid_instr <= 0.
  - buf discarded; any ihit that cycle is discarded; next state FETCH.
  - Redirect overrides stall.
- halt (any state): go to HALTED; ifid_valid <= 0; pc frozen.
- HALTED: imemREN=0, halted=1; ignores all inputs except RST.
- Arithmetic: pc+4 is a 32-bit modulo add, so 32'hFFFF_FFFC + 4 = 0. No alignment checks are made beyond masking redirect_pc.

## Timing
- Reset values while RST=1 and after release:
  - pc=PC_INIT; state=FETCH.
  - ifid_instr=0, ifid_pc=0, ifid_npc=0, ifid_valid=0.
  - halted=0, buf=0.
  - imemREN is forced to 0 while RST=1 and is 1 from the first cycle after release.
- imemREN and imemaddr are combinational from state and pc. They do not depend on ihit.
- Latency: an ihit in cycle N with no stall makes the instruction visible on ifid_* after edge N+1. Throughput is one instruction per cycle while ihit is held high.
- Stall released in cycle M from BUFFERED: buffered instruction appears after edge M+1; the next fetch request starts in cycle M+1.
- RST asserted mid-fetch or mid-buffer returns everything to reset values immediately (asynchronous). The pending memory response is ignored.
- Simultaneous redirect & ihit: the fetched word is dropped, and the new PC is requested next cycle.

## Test plan
- Reset then ihit=1 constantly, imemload = 32'h2001_0005, 32'h2002_0003, 32'h0022_1820 -> ifid_pc 0, 4, 8 on consecutive cycles; ifid_npc = ifid_pc+4; ifid_valid=1.
- ihit low for 3 cycles at pc=8 -> imemREN=1, imemaddr=8 held; ifid_valid=0 for those cycles; then the instruction at 8 is latched.
- stall=1 in the same cycle as ihit with imemload=32'h8C41_0000 at pc=12 -> state BUFFERED, imemREN=0, IF/ID unchanged. Stall released 2 cycles later -> ifid_instr=32'h8C41_0000, ifid_pc=12; next imemaddr=16.
- redirect=1, redirect_pc=32'h0000_0042 together with ihit and stall -> ifid_valid=0, ifid_instr=0; next imemaddr=32'h40. Repeat while in BUFFERED -> buffer dropped.
- PC_INIT=32'hFFFF_FFFC, one ihit -> ifid_npc=0, next imemaddr=0.
- halt=1 while fetching -> halted=1 and imemREN=0 from the next cycle, ifid_valid=0, and redirect/ihit are ignored. RST pulse mid-operation -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, issues imem reads,
// and holds a one-entry buffer for a word that returns while decode is stalled.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read request active at pc; latch or buffer on ihit
// BUFFERED | returned word parked in buf_*; waiting for stall to clear
// HALTED   | fetch stopped until reset; all inputs ignored
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    // Request is gated by RST so memory sees no read while the stage is held in reset.
    assign imemREN  = (state == FETCH) && !RST;
    assign imemaddr = pc;
    assign halted   = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            buf_instr  <= 32'h0;
            buf_pc     <= 32'h0;
            ifid_instr <= 32'h0;
            ifid_pc    <= 32'h0;
            ifid_npc   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (state != HALTED) begin
            if (halt) begin
                state      <= HALTED;
                ifid_valid <= 1'b0;
            end else if (redirect) begin
                pc         <= {redirect_pc[31:2], 2'b00};
                ifid_instr <= 32'h0;
                ifid_valid <= 1'b0;
                buf_instr  <= 32'h0;
                buf_pc     <= 32'h0;
                state      <= FETCH;
            end else if (state == FETCH) begin
                if (ihit && !stall) begin
                    ifid_instr <= imemload;
                    ifid_pc    <= pc;
                    ifid_npc   <= pc + 32'd4;
                    ifid_valid <= 1'b1;
                    pc         <= pc + 32'd4;
                end else if (ihit && stall) begin
                    buf_instr <= imemload;
                    buf_pc    <= pc;
                    state     <= BUFFERED;
                end else if (!stall) begin
                    ifid_valid <= 1'b0;
                end
            end else if (!stall) begin
                ifid_instr <= buf_instr;
                ifid_pc    <= buf_pc;
                ifid_npc   <= buf_pc + 32'd4;
                ifid_valid <= 1'b1;
                pc         <= buf_pc + 32'd4;
                state      <= FETCH;
            end
        end
    end

endmodule
